zap_branch_resolve: RTL

- Resolves branch predictions in the ALU stage and generates the feedback the fetch-side predictor consumes: a mispredict clear or a correct-prediction confirm, plus the fetch-relative PC that indexes the predictor table.
- Also produces the redirect PC for fetch.
- Squashes wrong-path instructions that arrive in the shadow of a mispredict.
- Keeps saturating statistics counters.

---
 rtl/zap_branch_resolve_if.sv | 36 +++
 rtl/zap_branch_resolve.sv | 83 ++++++++
 2 files changed

// File: rtl/zap_branch_resolve_if.sv
// Pipeline-side bundle for the ALU-stage branch resolver: resolution inputs in,
// predictor feedback, redirect PC and statistics out.
interface zap_branch_resolve_if #(
  parameter int unsigned STAT_WIDTH = 16
);
  logic                  i_clear_from_writeback;
  logic                  i_data_stall;
  logic                  i_val;
  logic                  i_is_branch;
  logic                  i_cond_pass;
  logic                  i_taken_pred;
  logic                  i_thumb;
  logic [31:0]           i_pc_plus_8;
  logic [31:0]           i_target;
  logic                  o_clear_from_alu;
  logic                  o_confirm_from_alu;
  logic [31:0]           o_pc_from_alu;
  logic [31:0]           o_redirect_pc;
  logic [STAT_WIDTH-1:0] o_branch_cnt;
  logic [STAT_WIDTH-1:0] o_mispredict_cnt;
  logic                  o_busy;

  modport master (
    output i_clear_from_writeback, i_data_stall, i_val, i_is_branch,
           i_cond_pass, i_taken_pred, i_thumb, i_pc_plus_8, i_target,
    input  o_clear_from_alu, o_confirm_from_alu, o_pc_from_alu,
           o_redirect_pc, o_branch_cnt, o_mispredict_cnt, o_busy
  );

  modport slave (
    input  i_clear_from_writeback, i_data_stall, i_val, i_is_branch,
           i_cond_pass, i_taken_pred, i_thumb, i_pc_plus_8, i_target,
    output o_clear_from_alu, o_confirm_from_alu, o_pc_from_alu,
           o_redirect_pc, o_branch_cnt, o_mispredict_cnt, o_busy
  );
endinterface

// File: rtl/zap_branch_resolve.sv
// ALU-stage branch resolution: predictor clear/confirm feedback, fetch redirect,
// wrong-path squash window and saturating branch statistics.
module zap_branch_resolve #(
  parameter int unsigned SQUASH_CYCLES = 1,
  parameter int unsigned STAT_WIDTH    = 16
) (
  input logic                 i_clk,
  input logic                 i_reset,
  zap_branch_resolve_if.slave bus
);

  typedef enum logic {IDLE, SQUASH} state_t;

  state_t      state;
  logic [2:0]  squash_cnt;
  logic        actual;
  logic        mis;
  logic [31:0] inst_pc;
  logic [31:0] seq_pc;

  always_comb begin
    actual  = bus.i_is_branch & bus.i_cond_pass;
    mis     = (actual != bus.i_taken_pred);
    inst_pc = bus.i_pc_plus_8 - (bus.i_thumb ? 32'd4 : 32'd8);
    seq_pc  = inst_pc + (bus.i_thumb ? 32'd2 : 32'd4);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                  <= IDLE;
      squash_cnt             <= '0;
      bus.o_clear_from_alu   <= 1'b0;
      bus.o_confirm_from_alu <= 1'b0;
      bus.o_pc_from_alu      <= '0;
      bus.o_redirect_pc      <= '0;
      bus.o_branch_cnt       <= '0;
      bus.o_mispredict_cnt   <= '0;
      bus.o_busy             <= 1'b0;
    end else if (bus.i_clear_from_writeback) begin
      state                  <= IDLE;
      squash_cnt             <= '0;
      bus.o_clear_from_alu   <= 1'b0;
      bus.o_confirm_from_alu <= 1'b0;
      bus.o_busy             <= 1'b0;
    end else if (!bus.i_data_stall) begin
      // Pulses default low; a stall skips this branch so a pending pulse is held.
      bus.o_clear_from_alu   <= 1'b0;
      bus.o_confirm_from_alu <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_val) begin
            if (mis) begin
              bus.o_clear_from_alu <= 1'b1;
              bus.o_pc_from_alu    <= inst_pc;
              bus.o_redirect_pc    <= actual ? bus.i_target : seq_pc;
              state                <= SQUASH;
              squash_cnt           <= 3'(SQUASH_CYCLES);
              bus.o_busy           <= 1'b1;
              if (bus.o_mispredict_cnt != '1)
                bus.o_mispredict_cnt <= bus.o_mispredict_cnt + 1'b1;
            end else if (bus.i_is_branch) begin
              bus.o_confirm_from_alu <= 1'b1;
              bus.o_pc_from_alu      <= inst_pc;
            end
            if (bus.i_is_branch && bus.o_branch_cnt != '1)
              bus.o_branch_cnt <= bus.o_branch_cnt + 1'b1;
          end
        end
        SQUASH: begin
          if (squash_cnt <= 3'd1) begin
            state      <= IDLE;
            squash_cnt <= '0;
            bus.o_busy <= 1'b0;
          end else begin
            squash_cnt <= squash_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
